// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types used by the fetch-redirect sequencer.
package lc3b_types;

  localparam int PC_W_DEF  = 16;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } redirect_state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_EX   = 2'd1,
    SRC_MEM  = 2'd2
  } redirect_src_t;

endpackage

// File: rtl/redirect_perf_counters.sv
// Three saturating event counters for redirect activity.
// Only instantiated when FLUSH_PERF_EN is defined.
module redirect_perf_counters
  import lc3b_types::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_mispred,
  input  logic             inc_mem_redir,
  input  logic             inc_wait,
  output logic [CNT_W-1:0] perf_mispred,
  output logic [CNT_W-1:0] perf_mem_redir,
  output logic [CNT_W-1:0] perf_wait_cyc
);

  logic [CNT_W-1:0] mispred_q, mispred_d;
  logic [CNT_W-1:0] mem_redir_q, mem_redir_d;
  logic [CNT_W-1:0] wait_cyc_q, wait_cyc_d;

  // Increment on each event but stick at all-ones instead of wrapping.
  always_comb begin
    mispred_d   = mispred_q;
    mem_redir_d = mem_redir_q;
    wait_cyc_d  = wait_cyc_q;
    if (inc_mispred && !(&mispred_q))     mispred_d   = mispred_q + CNT_W'(1);
    if (inc_mem_redir && !(&mem_redir_q)) mem_redir_d = mem_redir_q + CNT_W'(1);
    if (inc_wait && !(&wait_cyc_q))       wait_cyc_d  = wait_cyc_q + CNT_W'(1);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mispred_q   <= '0;
      mem_redir_q <= '0;
      wait_cyc_q  <= '0;
    end else begin
      mispred_q   <= mispred_d;
      mem_redir_q <= mem_redir_d;
      wait_cyc_q  <= wait_cyc_d;
    end
  end

  assign perf_mispred   = mispred_q;
  assign perf_mem_redir = mem_redir_q;
  assign perf_wait_cyc  = wait_cyc_q;

endmodule

// File: rtl/redirect_ctrl.sv
// Fetch-redirect / flush sequencer for the 5-stage LC-3b pipeline.
// Arbitrates EX (mispredict / BTB miss) against MEM (JSR/JSRR/TRAP) redirects,
// squashes younger stages and holds the redirect PC until fetch takes it.
// Optional feature: define FLUSH_PERF_EN to add the perf_* counters and ports.
module redirect_ctrl
  import lc3b_types::*;
#(
  parameter int PC_W  = PC_W_DEF
`ifdef FLUSH_PERF_EN
  ,parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ex_br_ind,
  input  logic            ex_pred,
  input  logic            ex_btb_hit,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic [PC_W-1:0] ex_fallthru,
  input  logic            mem_redirect,
  input  logic [PC_W-1:0] mem_target,
  input  logic            if_ready,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            flush_ex_mem,
  output logic            busy
`ifdef FLUSH_PERF_EN
  ,output logic [CNT_W-1:0] perf_mispred
  ,output logic [CNT_W-1:0] perf_mem_redir
  ,output logic [CNT_W-1:0] perf_wait_cyc
`endif
);

  redirect_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  redirect_src_t   src;
  logic            ex_req;
  logic            mem_req;
  logic [PC_W-1:0] ex_tgt;

  // Decode raw EX/MEM control into requests; MEM is older so it wins, and
  // while a redirect is pending only MEM can replace it.
  always_comb begin
    ex_req  = ex_br_ind & ((ex_pred != ex_taken) | ~ex_btb_hit);
    ex_tgt  = ex_taken ? ex_target : ex_fallthru;
    mem_req = mem_redirect;
    src     = SRC_NONE;
    if (mem_req) begin
      src = SRC_MEM;
    end else if (ex_req && state_q == IDLE) begin
      src = SRC_EX;
    end
  end

  // State and redirect PC registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state: enter PEND on any accepted request, leave on handshake
  // unless a MEM override arrives in the same cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (src)
      SRC_MEM: pc_d = mem_target;
      SRC_EX:  pc_d = ex_tgt;
      default: pc_d = pc_q;
    endcase
    case (state_q)
      IDLE: if (src != SRC_NONE) state_d = PEND;
      PEND: if (!mem_req && if_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: flushes are combinational in the request cycle; PEND also
  // squashes the wrong-path fetch slot every cycle.
  always_comb begin
    redirect_valid = (state_q == PEND);
    busy           = (state_q == PEND);
    redirect_pc    = pc_q;
    flush_if_id    = (state_q == PEND) || (src != SRC_NONE);
    flush_id_ex    = (src != SRC_NONE);
    flush_ex_mem   = (src == SRC_MEM);
  end

  // EX is a squashed bubble while a redirect is pending.
  assert property (@(posedge clk) disable iff (!reset_n)
                   !(state_q == PEND && ex_br_ind));

`ifdef FLUSH_PERF_EN
  redirect_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk           (clk),
    .reset_n       (reset_n),
    .inc_mispred   (src == SRC_EX),
    .inc_mem_redir (src == SRC_MEM),
    .inc_wait      ((state_q == PEND) && !if_ready),
    .perf_mispred  (perf_mispred),
    .perf_mem_redir(perf_mem_redir),
    .perf_wait_cyc (perf_wait_cyc)
  );
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed self-checking bench for redirect_ctrl.
module tb_redirect_ctrl;

  logic        clk;
  logic        reset_n;
  logic        ex_br_ind;
  logic        ex_pred;
  logic        ex_btb_hit;
  logic        ex_taken;
  logic [15:0] ex_target;
  logic [15:0] ex_fallthru;
  logic        mem_redirect;
  logic [15:0] mem_target;
  logic        if_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic        busy;
`ifdef FLUSH_PERF_EN
  logic [15:0] perf_mispred;
  logic [15:0] perf_mem_redir;
  logic [15:0] perf_wait_cyc;
  int          exp_mispred;
  int          exp_mem_redir;
  int          exp_wait;
`endif

  int tests;
  int errors;

  redirect_ctrl #(
    .PC_W(16)
`ifdef FLUSH_PERF_EN
    ,.CNT_W(16)
`endif
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ex_br_ind     (ex_br_ind),
    .ex_pred       (ex_pred),
    .ex_btb_hit    (ex_btb_hit),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .ex_fallthru   (ex_fallthru),
    .mem_redirect  (mem_redirect),
    .mem_target    (mem_target),
    .if_ready      (if_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .flush_ex_mem  (flush_ex_mem),
    .busy          (busy)
`ifdef FLUSH_PERF_EN
    ,.perf_mispred  (perf_mispred)
    ,.perf_mem_redir(perf_mem_redir)
    ,.perf_wait_cyc (perf_wait_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    ex_br_ind    = 1'b0;
    ex_pred      = 1'b0;
    ex_btb_hit   = 1'b0;
    ex_taken     = 1'b0;
    ex_target    = 16'h3040;
    ex_fallthru  = 16'h3002;
    mem_redirect = 1'b0;
    mem_target   = 16'h0000;
    if_ready     = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", redirect_valid); end
    tests++; if (redirect_pc !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0000", redirect_pc); end
    tests++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests++; if ({flush_if_id, flush_id_ex, flush_ex_mem} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flush: got %b expected 000", {flush_if_id, flush_id_ex, flush_ex_mem}); end
`ifdef FLUSH_PERF_EN
    tests++; if (perf_mispred !== 16'd0 || perf_mem_redir !== 16'd0 || perf_wait_cyc !== 16'd0) begin errors++; $display("[TB] FAIL reset_perf: got %0d/%0d/%0d expected 0/0/0", perf_mispred, perf_mem_redir, perf_wait_cyc); end
    exp_mispred = 0; exp_mem_redir = 0; exp_wait = 0;
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ex_mispredict();
    ex_br_ind = 1'b1; ex_pred = 1'b0; ex_taken = 1'b1; ex_btb_hit = 1'b1;
    ex_target = 16'h3040; if_ready = 1'b1;
    #1;
    tests++; if ({flush_if_id, flush_id_ex, flush_ex_mem} !== 3'b110) begin errors++; $display("[TB] FAIL ex_flush: got %b expected 110", {flush_if_id, flush_id_ex, flush_ex_mem}); end
    tests++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL ex_valid_n: got %b expected 0", redirect_valid); end
    @(negedge clk);
    clear_inputs();
    #1;
`ifdef FLUSH_PERF_EN
    exp_mispred++;
`endif
    tests++; if (redirect_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL ex_pend: got valid=%b busy=%b expected 1 1", redirect_valid, busy); end
    tests++; if (redirect_pc !== 16'h3040) begin errors++; $display("[TB] FAIL ex_pc: got %h expected 3040", redirect_pc); end
    tests++; if ({flush_if_id, flush_id_ex, flush_ex_mem} !== 3'b100) begin errors++; $display("[TB] FAIL ex_pend_flush: got %b expected 100", {flush_if_id, flush_id_ex, flush_ex_mem}); end
    @(negedge clk);
    #1;
    tests++; if (redirect_valid !== 1'b0 || busy !== 1'b0 || flush_if_id !== 1'b0) begin errors++; $display("[TB] FAIL ex_idle: got valid=%b busy=%b fif=%b expected 0 0 0", redirect_valid, busy, flush_if_id); end
`ifdef FLUSH_PERF_EN
    tests++; if (perf_mispred !== 16'(exp_mispred)) begin errors++; $display("[TB] FAIL ex_perf: got %0d expected %0d", perf_mispred, exp_mispred); end
`endif
  endtask

  task automatic test_ex_redirects();
    // {pred, taken, btb_hit}, request expected, PC expected
    logic [2:0]  vec     [7] = '{3'b011, 3'b110, 3'b100, 3'b111, 3'b001, 3'b101, 3'b000};
    logic        exp_req [7] = '{1'b1,   1'b1,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1};
    logic [15:0] exp_pc  [7] = '{16'h3040, 16'h3040, 16'h3002, 16'h0, 16'h0, 16'h3002, 16'h3002};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ex_br_ind = 1'b1;
      {ex_pred, ex_taken, ex_btb_hit} = vec[i];
      #1;
      tests++; if (flush_id_ex !== exp_req[i] || flush_ex_mem !== 1'b0) begin errors++; $display("[TB] FAIL vec%0d_flush: got id_ex=%b ex_mem=%b expected %b 0", i, flush_id_ex, flush_ex_mem, exp_req[i]); end
      @(negedge clk);
      clear_inputs();
      #1;
      tests++; if (redirect_valid !== exp_req[i]) begin errors++; $display("[TB] FAIL vec%0d_valid: got %b expected %b", i, redirect_valid, exp_req[i]); end
      if (exp_req[i]) begin
`ifdef FLUSH_PERF_EN
        exp_mispred++;
`endif
        tests++; if (redirect_pc !== exp_pc[i]) begin errors++; $display("[TB] FAIL vec%0d_pc: got %h expected %h", i, redirect_pc, exp_pc[i]); end
      end
    end
    @(negedge clk);
`ifdef FLUSH_PERF_EN
    tests++; if (perf_mispred !== 16'(exp_mispred)) begin errors++; $display("[TB] FAIL vec_perf: got %0d expected %0d", perf_mispred, exp_mispred); end
`endif
  endtask

  task automatic test_mem_over_ex();
    @(negedge clk);
    ex_br_ind = 1'b1; ex_pred = 1'b0; ex_taken = 1'b1; ex_btb_hit = 1'b1;
    mem_redirect = 1'b1; mem_target = 16'h0400;
    #1;
    tests++; if ({flush_if_id, flush_id_ex, flush_ex_mem} !== 3'b111) begin errors++; $display("[TB] FAIL mem_flush: got %b expected 111", {flush_if_id, flush_id_ex, flush_ex_mem}); end
    @(negedge clk);
    clear_inputs();
    #1;
`ifdef FLUSH_PERF_EN
    exp_mem_redir++;
`endif
    tests++; if (redirect_pc !== 16'h0400 || redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL mem_pc: got %h valid=%b expected 0400 1", redirect_pc, redirect_valid); end
`ifdef FLUSH_PERF_EN
    tests++; if (perf_mispred !== 16'(exp_mispred) || perf_mem_redir !== 16'(exp_mem_redir)) begin errors++; $display("[TB] FAIL mem_perf: got %0d/%0d expected %0d/%0d", perf_mispred, perf_mem_redir, exp_mispred, exp_mem_redir); end
`endif
    @(negedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mem_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_wait();
    @(negedge clk);
    ex_br_ind = 1'b1; ex_pred = 1'b1; ex_taken = 1'b0; ex_btb_hit = 1'b1;
    if_ready = 1'b0;
`ifdef FLUSH_PERF_EN
    exp_mispred++;
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ex_br_ind = 1'b0;
      #1;
      tests++; if (redirect_valid !== 1'b1 || busy !== 1'b1 || flush_if_id !== 1'b1 || redirect_pc !== 16'h3002) begin errors++; $display("[TB] FAIL wait%0d: got valid=%b busy=%b fif=%b pc=%h expected 1 1 1 3002", i, redirect_valid, busy, flush_if_id, redirect_pc); end
    end
`ifdef FLUSH_PERF_EN
    exp_wait += 5;
`endif
    @(negedge clk);
    if_ready = 1'b1;
    #1;
    tests++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL wait_hold: got %b expected 1", redirect_valid); end
    @(negedge clk);
    #1;
    tests++; if (redirect_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL wait_done: got valid=%b busy=%b expected 0 0", redirect_valid, busy); end
`ifdef FLUSH_PERF_EN
    tests++; if (perf_wait_cyc !== 16'(exp_wait)) begin errors++; $display("[TB] FAIL wait_perf: got %0d expected %0d", perf_wait_cyc, exp_wait); end
`endif
  endtask

  task automatic test_pend_override();
    @(negedge clk);
    ex_br_ind = 1'b1; ex_pred = 1'b0; ex_taken = 1'b1; ex_btb_hit = 1'b1;
    ex_target = 16'h3040; if_ready = 1'b0;
`ifdef FLUSH_PERF_EN
    exp_mispred++;
`endif
    @(negedge clk);
    ex_br_ind = 1'b0;
    #1;
    tests++; if (redirect_pc !== 16'h3040) begin errors++; $display("[TB] FAIL ovr_first_pc: got %h expected 3040", redirect_pc); end
    mem_redirect = 1'b1; mem_target = 16'h0020; if_ready = 1'b1;
    #1;
    tests++; if ({flush_if_id, flush_id_ex, flush_ex_mem} !== 3'b111) begin errors++; $display("[TB] FAIL ovr_flush: got %b expected 111", {flush_if_id, flush_id_ex, flush_ex_mem}); end
`ifdef FLUSH_PERF_EN
    exp_mem_redir++;
`endif
    @(negedge clk);
    clear_inputs();
    #1;
    tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0020) begin errors++; $display("[TB] FAIL ovr_pend: got valid=%b pc=%h expected 1 0020", redirect_valid, redirect_pc); end
    @(negedge clk);
    #1;
    tests++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_done: got %b expected 0", redirect_valid); end
`ifdef FLUSH_PERF_EN
    tests++; if (perf_mem_redir !== 16'(exp_mem_redir) || perf_wait_cyc !== 16'(exp_wait)) begin errors++; $display("[TB] FAIL ovr_perf: got %0d/%0d expected %0d/%0d", perf_mem_redir, perf_wait_cyc, exp_mem_redir, exp_wait); end
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ex_br_ind = 1'b1; ex_pred = 1'b0; ex_taken = 1'b1; ex_btb_hit = 1'b1; ex_target = 16'h1111;
    @(negedge clk);
    clear_inputs();
    #1;
    tests++; if (redirect_pc !== 16'h1111) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 1111", redirect_pc); end
    @(negedge clk);
    ex_br_ind = 1'b1; ex_pred = 1'b1; ex_taken = 1'b1; ex_btb_hit = 1'b0; ex_target = 16'h2222;
    #1;
    tests++; if (busy !== 1'b0 || flush_id_ex !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept: got busy=%b id_ex=%b expected 0 1", busy, flush_id_ex); end
    @(negedge clk);
    clear_inputs();
    #1;
    tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 16'h2222) begin errors++; $display("[TB] FAIL b2b_second: got valid=%b pc=%h expected 1 2222", redirect_valid, redirect_pc); end
`ifdef FLUSH_PERF_EN
    exp_mispred += 2;
    tests++; if (perf_mispred !== 16'(exp_mispred)) begin errors++; $display("[TB] FAIL b2b_perf: got %0d expected %0d", perf_mispred, exp_mispred); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid_pend();
    @(negedge clk);
    ex_br_ind = 1'b1; ex_pred = 1'b0; ex_taken = 1'b1; ex_btb_hit = 1'b1;
    ex_target = 16'h3040; if_ready = 1'b0;
    @(negedge clk);
    ex_br_ind = 1'b0;
    #1;
    tests++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre: got %b expected 1", redirect_valid); end
    reset_n = 1'b0;
    #1;
    tests++; if (redirect_valid !== 1'b0 || busy !== 1'b0 || redirect_pc !== 16'h0000 || flush_if_id !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid: got valid=%b busy=%b pc=%h fif=%b expected 0 0 0000 0", redirect_valid, busy, redirect_pc, flush_if_id); end
`ifdef FLUSH_PERF_EN
    tests++; if (perf_mispred !== 16'd0 || perf_wait_cyc !== 16'd0) begin errors++; $display("[TB] FAIL rst_perf: got %0d/%0d expected 0/0", perf_mispred, perf_wait_cyc); end
`endif
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (redirect_valid !== 1'b0 || busy !== 1'b0 || redirect_pc !== 16'h0000) begin errors++; $display("[TB] FAIL rst_after: got valid=%b busy=%b pc=%h expected 0 0 0000", redirect_valid, busy, redirect_pc); end
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_ex_mispredict();
    test_ex_redirects();
    test_mem_over_ex();
    test_wait();
    test_pend_override();
    test_back_to_back();
    test_reset_mid_pend();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
